// File: rtl/matrix_mem_arbiter_if.sv
// Requester and memory-side signal bundle for matrix_mem_arbiter.
// The master modport is the arbiter side, and the slave modport is the requester/memory side.
interface matrix_mem_arbiter_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 8
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_rw;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        done;
    logic                   err;
    logic [DATA_W-1:0]      rdata;
    logic                   mem_en;
    logic                   mem_rw;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;
    logic                   mem_flag;
    logic                   busy;

    modport master (
        input  req, req_rw, req_addr, req_wdata, mem_rdata, mem_flag,
        output grant, done, err, rdata, mem_en, mem_rw, mem_addr, mem_wdata, busy
    );

    modport slave (
        output req, req_rw, req_addr, req_wdata, mem_rdata, mem_flag,
        input  grant, done, err, rdata, mem_en, mem_rw, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/matrix_mem_arbiter.sv
// Single-port Mem arbiter for matrix units: one latched read/write transaction per grant.
// Round-robin by default; define MATRIX_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest).
module matrix_mem_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned DATA_W   = 256,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned MAX_WAIT = 15
) (
    input logic                  clk,
    input logic                  RESET,
    matrix_mem_arbiter_if.master bus
);
    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              found;
    logic [IDXW-1:0]   win_idx;
    logic [IDXW-1:0]   cand;
`ifndef MATRIX_ARB_FIXED_PRIO_EN
    logic [IDXW-1:0]   rr_q, rr_d;
    logic [IDXW-1:0]   win_q, win_d;
    int unsigned       cand_sum;
`endif

    // Winner search: first asserted request starting at rr (or at 0 in fixed priority).
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
`ifndef MATRIX_ARB_FIXED_PRIO_EN
        cand_sum = 0;
`endif
        for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef MATRIX_ARB_FIXED_PRIO_EN
            cand = IDXW'(i);
`else
            cand_sum = 32'(rr_q) + i;
            cand     = IDXW'((cand_sum >= NREQ) ? (cand_sum - NREQ) : cand_sum);
`endif
            if (!found && bus.req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = done_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_en_d    = mem_en_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
`ifndef MATRIX_ARB_FIXED_PRIO_EN
        rr_d        = rr_q;
        win_d       = win_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d     = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    mem_rw_d    = bus.req_rw[win_idx];
                    mem_addr_d  = bus.req_addr[win_idx*ADDR_W +: ADDR_W];
                    mem_wdata_d = bus.req_wdata[win_idx*DATA_W +: DATA_W];
                    mem_en_d    = 1'b1;
                    cnt_d       = '0;
`ifndef MATRIX_ARB_FIXED_PRIO_EN
                    win_d       = win_idx;
`endif
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                // The flag takes precedence over a timeout that is reached in the same cycle.
                if (bus.mem_flag) begin
                    mem_en_d = 1'b0;
                    if (!mem_rw_q) rdata_d = bus.mem_rdata;
                    done_d   = grant_q;
                    state_d  = S_DONE;
                end else if (cnt_d == 8'(MAX_WAIT)) begin
                    mem_en_d = 1'b0;
                    err_d    = 1'b1;
                    done_d   = grant_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                grant_d = '0;
                done_d  = '0;
                err_d   = 1'b0;
`ifndef MATRIX_ARB_FIXED_PRIO_EN
                rr_d    = (win_q == IDXW'(NREQ - 1)) ? '0 : win_q + 1'b1;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
`ifndef MATRIX_ARB_FIXED_PRIO_EN
            rr_q        <= '0;
            win_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
`ifndef MATRIX_ARB_FIXED_PRIO_EN
            rr_q        <= rr_d;
            win_q       <= win_d;
`endif
        end
    end

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_rw    = mem_rw_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_matrix_mem_arbiter.sv
// Scoreboard bench for matrix_mem_arbiter: the stimulus pushes the expected completions into a queue,
// and a monitor checks each done pulse against them.
module tb_matrix_mem_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 256;
    localparam int unsigned AW   = 8;
    localparam int unsigned MW   = 15;

    typedef struct {
        logic [3:0]   done;
        logic         err;
        logic         chk_rd;
        logic [255:0] rdata;
        logic [7:0]   addr;
        logic         rw;
        logic [255:0] wdata;
        int           lat;
    } exp_t;

    logic clk   = 1'b0;
    logic RESET = 1'b1;

    matrix_mem_arbiter_if #(.NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW)) bus ();

    matrix_mem_arbiter #(.NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_pass = 0;
    int         n_total = 0;
    int         cyc = 0;
    int         gstart = 0;
    int         flag_at = 0;
    int         acnt = 0;
    logic [3:0] prev_grant = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: no response within cycle budget", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: raises mem_flag during the flag_at-th cycle of mem_en; a flag_at of 0 means never.
    always @(negedge clk) begin
        if (bus.mem_en) begin
            acnt = acnt + 1;
            bus.mem_flag = (flag_at != 0) && (acnt == flag_at);
        end else begin
            acnt = 0;
            bus.mem_flag = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.grant != '0 && prev_grant == '0) gstart = cyc;
        prev_grant = bus.grant;
        if (!RESET && bus.done != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", bus.done, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("done", bus.done, mon_e.done);
                chk("grant_in_done", bus.grant, mon_e.done);
                chk("err", bus.err, mon_e.err);
                if (mon_e.chk_rd) chk("rdata", bus.rdata, mon_e.rdata);
                chk("mem_addr", bus.mem_addr, mon_e.addr);
                chk("mem_rw", bus.mem_rw, mon_e.rw);
                if (mon_e.rw) chk("mem_wdata", bus.mem_wdata, mon_e.wdata);
                chk("latency", cyc - gstart, mon_e.lat);
                chk("mem_en_off", bus.mem_en, 0);
            end
        end
    end

    task automatic set_req(input int i, input logic rw, input logic [7:0] a, input logic [255:0] wd);
        bus.req_rw[i]             = rw;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = wd;
        bus.req[i]                = 1'b1;
    endtask

    task automatic push(input logic [3:0] d, input logic e, input logic crd, input logic [255:0] rd,
                        input logic [7:0] a, input logic rw, input logic [255:0] wd, input int lat);
        exp_t x;
        x.done = d; x.err = e; x.chk_rd = crd; x.rdata = rd;
        x.addr = a; x.rw = rw; x.wdata = wd; x.lat = lat;
        sb.push_back(x);
    endtask

    task automatic wait_grant(input logic [3:0] exp_g);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.grant != '0) begin
                chk("grant", bus.grant, exp_g);
                chk("mem_en_on", bus.mem_en, 1);
                chk("busy", bus.busy, 1);
                return;
            end
        end
        timeout_fail("grant_wait");
    endtask

    task automatic wait_done(input int i);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.done[i]) begin
                bus.req[i] = 1'b0;
                return;
            end
        end
        timeout_fail("done_wait");
        bus.req[i] = 1'b0;
    endtask

    task automatic txn(input int i, input logic rw, input logic [7:0] a, input logic [255:0] wd,
                       input int fa, input logic [255:0] mrd, input logic e, input logic crd,
                       input logic [255:0] erd, input int lat);
        flag_at       = fa;
        bus.mem_rdata = mrd;
        set_req(i, rw, a, wd);
        push(4'b0001 << i, e, crd, erd, a, rw, wd, lat);
        wait_grant(4'b0001 << i);
        wait_done(i);
    endtask

    logic [255:0] a5;
    logic [3:0]   rr_exp[5];
    int           j;
    bit           got;

    initial begin
        a5            = {32{8'hA5}};
        bus.req       = '0;
        bus.req_rw    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", bus.grant, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_busy", bus.busy, 0);
        RESET = 1'b0;
        @(negedge clk);

        // Write, then a read, then a read that times out (rdata must keep 1234), then a flag in the last allowed cycle.
        txn(1, 1'b1, 8'h10, a5, 2, '0, 1'b0, 1'b0, '0, 2);
        txn(0, 1'b0, 8'h20, '0, 1, 256'h1234, 1'b0, 1'b1, 256'h1234, 1);
        bus.mem_rdata = 256'hFFFF;
        repeat (3) @(negedge clk);
        chk("rdata_hold", bus.rdata, 256'h1234);
        txn(2, 1'b0, 8'h30, '0, 0, 256'hDEAD, 1'b1, 1'b1, 256'h1234, 15);
        txn(3, 1'b0, 8'h31, '0, 15, 256'hBEEF, 1'b0, 1'b1, 256'hBEEF, 15);

        // req_addr and req are changed mid-transaction; the latched values must win.
        flag_at = 5;
        set_req(3, 1'b1, 8'h33, 256'h3333);
        push(4'b1000, 1'b0, 1'b0, '0, 8'h33, 1'b1, 256'h3333, 5);
        wait_grant(4'b1000);
        @(negedge clk);
        bus.req_addr[3*AW +: AW] = 8'h77;
        bus.req_rw[3]            = 1'b0;
        bus.req[3]               = 1'b0;
        chk("mem_addr_latched", bus.mem_addr, 8'h33);
        wait_done(3);

        // Asynchronous reset during ACCESS.
        flag_at = 0;
        set_req(1, 1'b0, 8'h50, '0);
        wait_grant(4'b0010);
        @(posedge clk);
        #3 RESET = 1'b1;
        #1;
        chk("async_mem_en", bus.mem_en, 0);
        chk("async_grant", bus.grant, 0);
        chk("async_busy", bus.busy, 0);
        bus.req = '0;
        @(negedge clk);
        RESET = 1'b0;
        flag_at = 1;
        bus.mem_rdata = 256'h4242;
        set_req(2, 1'b0, 8'h42, '0);
        push(4'b0100, 1'b0, 1'b1, 256'h4242, 8'h42, 1'b0, '0, 1);
        @(posedge clk);
        #1 chk("grant_after_reset", bus.grant, 4'b0100);
        wait_done(2);

        // Arbitration order with all four requesters held high; each winner re-raises req after its done.
        @(negedge clk) RESET = 1'b1;
        @(negedge clk) RESET = 1'b0;
`ifdef MATRIX_ARB_FIXED_PRIO_EN
        rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        flag_at = 1;
        bus.mem_rdata = 256'h77;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(8'h60 + i), '0);
        for (int k = 0; k < 5; k++) begin
            j = (rr_exp[k] == 4'b0001) ? 0 : (rr_exp[k] == 4'b0010) ? 1 : (rr_exp[k] == 4'b0100) ? 2 : 3;
            push(rr_exp[k], 1'b0, 1'b1, 256'h77, 8'(8'h60 + j), 1'b0, '0, 1);
        end
        for (int k = 0; k < 5; k++) begin
            got = 1'b0;
            for (int t = 0; t < 50 && !got; t++) begin
                @(negedge clk);
                if (bus.done != '0) got = 1'b1;
            end
            if (!got) begin
                timeout_fail("rr_done_wait");
                break;
            end
            j = bus.done[0] ? 0 : bus.done[1] ? 1 : bus.done[2] ? 2 : 3;
            bus.req[j] = 1'b0;
            if (k < 4) begin
                @(negedge clk);
                bus.req[j] = 1'b1;
            end else begin
                bus.req = '0;
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
